// File: rtl/csr_pkg.sv
// Shared CSR constants: register indices, AXI response code and word type.
// Imported by the AXI-lite responder and anything that decodes the CSR image.
package csr_pkg;

    localparam int CSR_REG_NUM      = 32;

    localparam int CSR_START        = 0;
    localparam int CSR_STATUS       = 1;
    localparam int CSR_PLAIN_LO     = 2;
    localparam int CSR_PLAIN_HI     = 26;
    localparam int CSR_PERF_DMA_DAT = 27;
    localparam int CSR_PERF_DMA_WT  = 28;
    localparam int CSR_PERF_FSM_DAT = 29;
    localparam int CSR_PERF_FSM_WT  = 30;
    localparam int CSR_VERSION      = CSR_REG_NUM - 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef logic [31:0] csr_word_t;

endpackage

// File: rtl/csr_axil_slave.sv
// AXI4-Lite CSR responder: write commits and BVALID one cycle after AW+W, RDATA/RVALID one cycle after AR.
// One write and one read outstanding; B/R held until BREADY/RREADY, which gates the next AW/W/AR accept.
module csr_axil_slave
    import csr_pkg::*;
#(
    parameter int        REG_NUM = CSR_REG_NUM,
    parameter int        ADDR_W  = $clog2(REG_NUM) + 2,
    parameter csr_word_t VERSION = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [REG_NUM*32-1:0] csr_out,
    output logic                  start_pulse,
    input  logic                  core_done,
    input  logic [4*32-1:0]       perf_cnt
);

    localparam int IDX_W   = ADDR_W - 2;
    localparam int VER_IDX = REG_NUM - 1;

    logic             aw_held_q, aw_held_d;
    logic             w_held_q, w_held_d;
    logic             bvalid_q, bvalid_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    csr_word_t        wdata_q, wdata_d;
    logic             rvalid_q, rvalid_d;
    csr_word_t        rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_q, start_d;
    csr_word_t        plain_q [CSR_PLAIN_LO:CSR_PLAIN_HI];
    csr_word_t        plain_d [CSR_PLAIN_LO:CSR_PLAIN_HI];
    csr_word_t        image   [REG_NUM];

    logic             aw_hs, w_hs, ar_hs, wr_fire;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    csr_word_t        wr_dat;

    // Protection, strobes and byte-lane address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = !rst && !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = !rst && !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = !rst && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign start_pulse   = start_q;

    // Write channel: a held beat and a fresh beat can complete the pair together.
    always_comb begin
        aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs      = S_AXI_WVALID && S_AXI_WREADY;
        wr_fire   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        wr_idx    = aw_held_q ? aw_idx_q : S_AXI_AWADDR[ADDR_W-1:2];
        wr_dat    = w_held_q ? wdata_q : S_AXI_WDATA;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        bvalid_d  = bvalid_q;
        if (wr_fire) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[ADDR_W-1:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = S_AXI_WDATA;
            end
            if (bvalid_q && S_AXI_BREADY) begin
                bvalid_d = 1'b0;
            end
        end
    end

    // Register updates; a start write beats a same-cycle done, and done beats a W1C.
    always_comb begin
        plain_d = plain_q;
        for (int i = CSR_PLAIN_LO; i <= CSR_PLAIN_HI; i++) begin
            if (wr_fire && wr_idx == IDX_W'(i)) begin
                plain_d[i] = wr_dat;
            end
        end
        start_d = wr_fire && (wr_idx == IDX_W'(CSR_START)) && wr_dat[0];
        busy_d  = busy_q;
        if (start_d) begin
            busy_d = 1'b1;
        end else if (core_done) begin
            busy_d = 1'b0;
        end
        done_d = done_q;
        if (core_done) begin
            done_d = 1'b1;
        end else if (wr_fire && (wr_idx == IDX_W'(CSR_STATUS)) && wr_dat[0]) begin
            done_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            image[i] = '0;
        end
        image[CSR_START]  = {31'b0, busy_q};
        image[CSR_STATUS] = {31'b0, done_q};
        for (int i = CSR_PLAIN_LO; i <= CSR_PLAIN_HI; i++) begin
            image[i] = plain_q[i];
        end
        for (int k = 0; k < 4; k++) begin
            image[CSR_PERF_DMA_DAT + k] = perf_cnt[32*k +: 32];
        end
        image[VER_IDX] = VERSION;
    end

    always_comb begin
        csr_out = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            csr_out[32*i +: 32] = image[i];
        end
    end

    // Read channel samples the pre-write image, so a same-cycle write is not visible.
    always_comb begin
        ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
        rd_idx   = S_AXI_ARADDR[ADDR_W-1:2];
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        if (ar_hs) begin
            rdata_d  = image[rd_idx];
            rvalid_d = 1'b1;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            for (int i = CSR_PLAIN_LO; i <= CSR_PLAIN_HI; i++) begin
                plain_q[i] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            start_q   <= start_d;
            plain_q   <= plain_d;
        end
    end

endmodule

// File: doc/csr_axil_slave.md
Name: csr_axil_slave

Overview:
- AXI4-Lite responder and CSR register file for the accelerator's control path.
- Responds to the CPU-side AXI-lite master. Receives 32-bit register writes and reads.
- Drives the flat CSR vector, a start pulse, and busy/done tracking into the compute core.
- Returns read-only performance counters at indices 27-30.

Parameters:
REG_NUM, 32, number of 32-bit CSRs; power of two.
ADDR_W, log2(REG_NUM)+2, byte address width; bits [1:0] ignored.
VERSION, 32'h0001_0000, constant returned at index REG_NUM-1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
S_AXI_AWVALID/AWREADY  in/out  1  write-address handshake
S_AXI_AWADDR  in  ADDR_W  write byte address
S_AXI_AWPROT  in  3  ignored
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  ignored; full-word writes only
S_AXI_WVALID/WREADY  in/out  1  write-data handshake
S_AXI_BRESP  out  2  always 2'b00
S_AXI_BVALID/BREADY  out/in  1  write response handshake
S_AXI_ARVALID/ARREADY  in/out  1  read-address handshake
S_AXI_ARADDR  in  ADDR_W  read byte address
S_AXI_ARPROT  in  3  ignored
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID/RREADY  out/in  1  read data handshake
csr_out  out  REG_NUM*32  flat register image; reg i at [32*i+:32]
start_pulse  out  1  one-cycle launch strobe
core_done  in  1  one-cycle completion strobe from core
perf_cnt  in  4*32  counters for regs 27..30; counter k at [32*k+:32]

Behaviour:
- Reset values: all registers 0. All VALID/READY outputs 0 during reset, and AWREADY/WREADY/ARREADY stay 0 while rst=1. start_pulse=0; busy=0; RDATA=0.
- Register index is ADDR[ADDR_W-1:2].
- Register map:
  - Reg 0, write: bit0=1 asserts start_pulse the next cycle, exactly 1 cycle, and sets busy. Reg 0 stores nothing.
  - Reg 0, read: {31'b0, busy}.
  - Reg 1: done_sticky in bit0. Set by core_done. Writing 1 to bit0 clears it (W1C).
  - Regs 2..26: plain read/write.
  - Regs 27..30: read-only; reads return perf_cnt[k] live. Writes are accepted with OKAY and discarded.
  - Reg REG_NUM-1: read-only VERSION.
  - csr_out carries stored values; read-only slots are driven from their sources.
- Write channel:
  - AW and W are accepted independently in any order or in the same cycle, and held in aw_held/w_held.
  - AWREADY = !aw_held & !BVALID. WREADY = !w_held & !BVALID.
  - The cycle after both are held, the register is updated, BVALID rises, and both held flags clear.
  - BVALID stays high until BREADY is sampled high. Only one write is outstanding at a time.
  - Minimum latency: AW+W handshake in cycle N gives the register update plus BVALID in N+1.
- Read channel:
  - ARREADY = !RVALID.
  - On an AR handshake in cycle N, RDATA is registered and RVALID rises in N+1.
  - RDATA/RVALID hold stable until RREADY. The next ARREADY comes in the cycle after the RREADY handshake.
- Simultaneous events:
  - Write and read in the same cycle are independent. A read of the register being written returns the old value.
  - core_done in the same cycle as a start write: busy=1 (start wins); done_sticky is set.
  - core_done in the same cycle as a W1C of reg 1: set wins.
  - start written while busy=1: start_pulse is still issued and busy stays 1.
- Reset mid-transaction: pending handshakes and held flags are abandoned. Registers return to 0. No response is issued for the aborted transaction.
- No error responses are generated; every address maps to a register.

Decomposition:
- Shared package csr_pkg holds:
  - register index constants: CSR_START=0, CSR_STATUS=1, CSR_PERF_DMA_DAT=27, CSR_PERF_DMA_WT=28, CSR_PERF_FSM_DAT=29, CSR_PERF_FSM_WT=30, CSR_VERSION=REG_NUM-1;
  - the OKAY response constant;
  - typedef csr_word_t (32 bits).
- No sub-module. The write FSM (held flags plus BVALID) and the read FSM (RVALID) are small enough to stay inline.

Test Plan:
- Same-cycle AW+W to 0x08 with data 0xDEADBEEF -> BVALID one cycle later with BRESP=0. A read of 0x08 -> RDATA=0xDEADBEEF one cycle after the AR handshake. csr_out[95:64]=0xDEADBEEF.
- W (0x12345678) two cycles before AW (0x0C), with BREADY held low 3 cycles -> BVALID stays high 3 cycles, AWREADY/WREADY stay low, and reg3 reads 0x12345678.
- Write 0x1 to 0x00 -> start_pulse high exactly 1 cycle and read of 0x00 = 1. Pulse core_done -> read 0x00 = 0 and read 0x04 = 1. Write 0x1 to 0x04 -> read 0x04 = 0.
- perf_cnt[0]=100, perf_cnt[3]=7. Read 0x6C (index 27) -> 100; read 0x78 (index 30) -> 7. Write 0xFFFF_FFFF to 0x6C -> OKAY, and a read still returns 100.
- RREADY held low 4 cycles after AR to 0x7C -> RDATA=0x0001_0000 stable throughout and ARREADY low until the cycle after the handshake.
- Assert rst while BVALID is pending -> BVALID=0 the next cycle and reg 2 reads 0.
